// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath with register file, 64-bit ALU and Z registers; divider built only when DATAPATH_DIV_EN is defined
module cpu_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin, Loin, PCin, IRin, MARin, MDRin, Yin, Zin, ZHIin, ZLOin,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout,
    input  logic        ZHighSelect, ZLowSelect, Cout, InPortout,
    input  logic        MDRread,
    input  logic        IncPC,
    input  logic [4:0]  ALU_opcode,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [31:0] HI, LO, Y, ZLO, ZHI, IR,
    output logic [63:0] Z_register
);
    logic [15:0] r_in, r_out;
    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d, zlo_q, zlo_d, zhi_q, zhi_d;
    logic [63:0] z_q, z_d;
    logic [31:0] bus, c_sign;
    logic [63:0] c, prod, div_c, ror_t, rol_t;
    logic signed [63:0] sa, sb;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    assign c_sign = {{13{ir_q[18]}}, ir_q[18:0]};

    // Lowest-numbered register wins, so the register loop overrides the other sources
    always_comb begin
        bus = HIout ? hi_q : Loout ? lo_q : ZHIout ? zhi_q : ZLOout ? zlo_q :
              ZHighSelect ? z_q[63:32] : ZLowSelect ? z_q[31:0] : PCout ? pc_q :
              MDRout ? mdr_q : Yout ? y_q : InPortout ? 32'h0 : Cout ? c_sign : 32'h0;
        for (int i = 15; i >= 0; i--)
            if (r_out[i]) bus = r_q[i];
    end

    assign sa    = {{32{y_q[31]}}, y_q};
    assign sb    = {{32{bus[31]}}, bus};
    assign prod  = sa * sb;
    assign ror_t = {y_q, y_q} >> bus[4:0];
    assign rol_t = {y_q, y_q} << bus[4:0];

`ifdef DATAPATH_DIV_EN
    logic [31:0] quo, rem;
    assign quo   = (bus == 32'h0) ? 32'hFFFFFFFF : $signed(y_q) / $signed(bus);
    assign rem   = (bus == 32'h0) ? y_q : $signed(y_q) % $signed(bus);
    assign div_c = {rem, quo};
`else
    assign div_c = 64'h0;
`endif

    always_comb begin
        c = 64'h0;
        case (ALU_opcode)
            5'b00000: c[31:0] = y_q + bus;
            5'b00001: c[31:0] = y_q - bus;
            5'b00010: c[31:0] = y_q & bus;
            5'b00011: c[31:0] = y_q | bus;
            5'b00100: c[31:0] = y_q >> bus[4:0];
            5'b00101: c[31:0] = $signed(y_q) >>> bus[4:0];
            5'b00110: c[31:0] = y_q << bus[4:0];
            5'b00111: c[31:0] = ror_t[31:0];
            5'b01000: c[31:0] = rol_t[63:32];
            5'b01001: c[31:0] = -bus;
            5'b01010: c[31:0] = ~bus;
            5'b01111: c = prod;
            5'b10000: c = div_c;
            default:  c = 64'h0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++)
            r_d[i] = r_in[i] ? bus : r_q[i];
        hi_d  = HIin ? bus : hi_q;
        lo_d  = Loin ? bus : lo_q;
        ir_d  = IRin ? bus : ir_q;
        mar_d = MARin ? bus : mar_q;
        y_d   = Yin ? bus : y_q;
        mdr_d = MDRin ? (MDRread ? Mdatain : bus) : mdr_q;
        pc_d  = IncPC ? pc_q + 32'd1 : PCin ? bus : pc_q;
        z_d   = Zin ? c : z_q;
        zlo_d = ZLOin ? c[31:0] : zlo_q;
        zhi_d = ZHIin ? c[63:32] : zhi_q;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q   <= '{default: 32'h0};
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            pc_q  <= 32'h0;
            ir_q  <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            y_q   <= 32'h0;
            zlo_q <= 32'h0;
            zhi_q <= 32'h0;
            z_q   <= 64'h0;
        end else begin
            r_q   <= r_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            zlo_q <= zlo_d;
            zhi_q <= zhi_d;
            z_q   <= z_d;
        end
    end

    assign R0  = r_q[0];
    assign R1  = r_q[1];
    assign R2  = r_q[2];
    assign R3  = r_q[3];
    assign R4  = r_q[4];
    assign R5  = r_q[5];
    assign R6  = r_q[6];
    assign R7  = r_q[7];
    assign R8  = r_q[8];
    assign R9  = r_q[9];
    assign R10 = r_q[10];
    assign R11 = r_q[11];
    assign R12 = r_q[12];
    assign R13 = r_q[13];
    assign R14 = r_q[14];
    assign R15 = r_q[15];
    assign HI  = hi_q;
    assign LO  = lo_q;
    assign Y   = y_q;
    assign ZLO = zlo_q;
    assign ZHI = zhi_q;
    assign IR  = ir_q;
    assign Z_register = z_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed scoreboard bench for cpu_datapath
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic [15:0] r_in, r_out;
    logic HIin, Loin, PCin, IRin, MARin, MDRin, Yin, Zin, ZHIin, ZLOin;
    logic HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout;
    logic ZHighSelect, ZLowSelect, Cout, InPortout, MDRread, IncPC;
    logic [4:0] ALU_opcode;
    logic [31:0] Mdatain;
    logic [31:0] rv [16];
    logic [31:0] hi, lo, y, zlo, zhi, ir;
    logic [63:0] zr;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb [$];
    int checks = 0;
    int errors = 0;

`ifdef DATAPATH_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic [4:0]  ops  [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                               5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01111,
                               5'b11111};
    logic [63:0] exps [13] = '{64'h00000000_800000F4, 64'h00000000_800000EC,
                               64'h00000000_00000000, 64'h00000000_800000F4,
                               64'h00000000_0800000F, 64'h00000000_F800000F,
                               64'h00000000_00000F00, 64'h00000000_0800000F,
                               64'h00000000_00000F08, 64'h00000000_FFFFFFFC,
                               64'h00000000_FFFFFFFB, 64'hFFFFFFFE_000003C0,
                               64'h00000000_00000000};

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .Yout(Yout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .ZHighSelect(ZHighSelect),
        .ZLowSelect(ZLowSelect), .Cout(Cout), .InPortout(InPortout),
        .MDRread(MDRread), .IncPC(IncPC), .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
        .R0(rv[0]), .R1(rv[1]), .R2(rv[2]), .R3(rv[3]), .R4(rv[4]), .R5(rv[5]),
        .R6(rv[6]), .R7(rv[7]), .R8(rv[8]), .R9(rv[9]), .R10(rv[10]), .R11(rv[11]),
        .R12(rv[12]), .R13(rv[13]), .R14(rv[14]), .R15(rv[15]),
        .HI(hi), .LO(lo), .Y(y), .ZLO(zlo), .ZHI(zhi), .IR(ir), .Z_register(zr)
    );

    task automatic idle();
        r_in = '0; r_out = '0;
        HIin = 0; Loin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0;
        Zin = 0; ZHIin = 0; ZLOin = 0;
        HIout = 0; Loout = 0; PCout = 0; MDRout = 0; Yout = 0; ZHIout = 0; ZLOout = 0;
        ZHighSelect = 0; ZLowSelect = 0; Cout = 0; InPortout = 0;
        MDRread = 0; IncPC = 0; ALU_opcode = 5'b00000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic mdr_load(input logic [31:0] v);
        idle();
        Mdatain = v; MDRread = 1; MDRin = 1;
        tick();
    endtask

    initial begin
        idle();
        Mdatain = '0;
        repeat (2) tick();
        push("rst_r5", 0); push("rst_hi", 0); push("rst_y", 0);
        push("rst_ir", 0); push("rst_zr", 0); push("rst_zlo", 0);
        chk(rv[5]); chk(hi); chk(y); chk(ir); chk(zr); chk(zlo);
        clr = 1;

        mdr_load(32'd15);
        idle(); MDRout = 1; r_in[6] = 1; push("r6_load", 15); tick(); chk(rv[6]);
        mdr_load(32'd4);
        idle(); MDRout = 1; r_in[7] = 1; push("r7_load", 4); tick(); chk(rv[7]);
        idle(); r_out[6] = 1; Yin = 1; push("y_from_r6", 15); tick(); chk(y);
        idle(); r_out[7] = 1; ALU_opcode = 5'b10000; ZLOin = 1; ZHIin = 1; tick();
        idle(); ZLOout = 1; Loin = 1; tick();
        idle(); ZHIout = 1; HIin = 1;
        push("div_lo", DIV_EN ? 64'd3 : 64'd0); push("div_hi", DIV_EN ? 64'd3 : 64'd0);
        tick(); chk(lo); chk(hi);

        mdr_load(32'hFFFFFFF1);
        idle(); MDRout = 1; Yin = 1; tick();
        idle(); r_out[7] = 1; ALU_opcode = 5'b10000; ZLOin = 1; ZHIin = 1;
        push("div_neg_zlo", DIV_EN ? 64'hFFFFFFFD : 64'h0);
        push("div_neg_zhi", DIV_EN ? 64'hFFFFFFFD : 64'h0);
        tick(); chk(zlo); chk(zhi);
        idle(); ALU_opcode = 5'b10000; ZLOin = 1; ZHIin = 1;
        push("div0_zlo", DIV_EN ? 64'hFFFFFFFF : 64'h0);
        push("div0_zhi", DIV_EN ? 64'hFFFFFFF1 : 64'h0);
        tick(); chk(zlo); chk(zhi);

        mdr_load(32'h00010000);
        idle(); MDRout = 1; Yin = 1; tick();
        idle(); MDRout = 1; ALU_opcode = 5'b01111; Zin = 1;
        push("mul_big", 64'h00000001_00000000); tick(); chk(zr);
        idle(); ZHighSelect = 1; ZLowSelect = 1; r_in[13] = 1;
        push("zhigh_sel", 1); tick(); chk(rv[13]);
        idle(); ZLowSelect = 1; PCout = 1; r_in[14] = 1; r_in[13] = 1; Yin = 1;
        push("zlow_sel", 0); tick(); chk(rv[14]);

        mdr_load(32'h800000F0);
        idle(); MDRout = 1; Yin = 1; tick();
        mdr_load(32'd4);
        for (int i = 0; i < 13; i++) begin
            idle(); MDRout = 1; ALU_opcode = ops[i]; Zin = 1;
            push($sformatf("alu_op%0d", ops[i]), exps[i]);
            tick(); chk(zr);
        end
        idle(); MDRout = 1; ALU_opcode = 5'b00000; ZLOin = 1;
        push("zlo_only", 64'h800000F4); push("z_hold", 0);
        tick(); chk(zlo); chk(zr);

        mdr_load(32'hA5A5A5A5);
        idle(); MDRout = 1; r_in[1] = 1; tick();
        idle(); r_out[1] = 1; r_out[6] = 1; HIout = 1; r_in[2] = 1;
        push("bus_prio", 64'hA5A5A5A5); tick(); chk(rv[2]);
        idle(); r_out[2] = 1; r_in[2] = 1; Yin = 1;
        push("self_reload", 64'hA5A5A5A5); push("y_self", 64'hA5A5A5A5);
        tick(); chk(rv[2]); chk(y);

        mdr_load(32'hFFFFFFFF);
        idle(); MDRout = 1; PCin = 1; tick();
        mdr_load(32'd5);
        idle(); MDRout = 1; IncPC = 1; PCin = 1; tick();
        idle(); PCout = 1; r_in[8] = 1; push("pc_wrap", 0); tick(); chk(rv[8]);
        idle(); IncPC = 1; tick();
        idle(); PCout = 1; r_in[9] = 1; push("pc_inc", 1); tick(); chk(rv[9]);

        mdr_load(32'h00040123);
        idle(); MDRout = 1; IRin = 1; push("ir_load", 64'h00040123); tick(); chk(ir);
        idle(); Cout = 1; r_in[10] = 1; push("cout_neg", 64'hFFFC0123); tick(); chk(rv[10]);
        mdr_load(32'hFFF30123);
        idle(); MDRout = 1; IRin = 1; tick();
        idle(); Cout = 1; r_in[11] = 1; push("cout_pos", 64'h00030123); tick(); chk(rv[11]);
        idle(); InPortout = 1; Cout = 1; r_in[11] = 1; push("inport", 0); tick(); chk(rv[11]);

        idle(); r_in = '1; Yin = 1; HIin = 1; Loin = 1; IRin = 1; MDRout = 1;
        Zin = 1; ZLOin = 1; ZHIin = 1; ALU_opcode = 5'b01010; clr = 0;
        push("clr_r2", 0); push("clr_r10", 0); push("clr_y", 0); push("clr_hi", 0);
        push("clr_ir", 0); push("clr_zr", 0); push("clr_zhi", 0);
        tick(); clr = 1;
        chk(rv[2]); chk(rv[10]); chk(y); chk(hi); chk(ir); chk(zr); chk(zhi);
        idle(); PCout = 1; r_in[0] = 1; push("clr_pc", 0); tick(); chk(rv[0]);
        idle(); MDRout = 1; r_in[1] = 1; push("clr_mdr", 0); tick(); chk(rv[1]);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, synchronous, active-low.
REQ-003 R0in..R15in, HIin, Loin, PCin, IRin, MARin, MDRin, Yin, Zin, ZHIin, ZLOin  in  1 each  register load enables, sampled at rising clk.
REQ-004 R0out..R15out, HIout, Loout, PCout, MDRout, Yout, ZHIout, ZLOout, ZHighSelect, ZLowSelect, Cout, InPortout  in  1 each  bus source selects.
REQ-005 MDRread  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
REQ-006 IncPC  in  1  PC increment request.
REQ-007 ALU_opcode  in  5  ALU operation select.
REQ-008 Mdatain  in  32  memory read data.
REQ-009 R0..R15, HI, LO, Y, ZLO, ZHI, IR  out  32 each  current register contents.
REQ-010 Z_register  out  64  current 64-bit Z contents {high,low}.

Function
REQ-011 Internal 32-bit bus = source selected by highest-priority asserted out signal, order R0out..R15out, HIout, Loout, ZHIout, ZLOout, ZHighSelect, ZLowSelect, PCout, MDRout, Yout, InPortout, Cout; none asserted -> 32'h0.
REQ-012 ZHighSelect drives Z_register[63:32]; ZLowSelect drives Z_register[31:0]; ZHIout/ZLOout drive ZHI/ZLO.
REQ-013 Cout drives IR[18:0] sign-extended to 32 bits; InPortout drives 32'h0 (no input port in this block).
REQ-014 Rn, HI, LO, IR, MAR, Y load bus when their in signal is 1 at rising clk; otherwise hold.
REQ-015 MDR loads (MDRread ? Mdatain : bus) when MDRin = 1.
REQ-016 PC: IncPC = 1 -> PC+1 (wraps at 32'hFFFFFFFF to 0); else PCin = 1 -> bus; IncPC has priority.
REQ-017 ALU combinational, A = Y, B = bus, 64-bit result C; C[63:32] = 0 except mul/div.
REQ-018 Opcodes: 00000 add, 00001 sub (A-B), 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol, 01001 neg (-B), 01010 not (~B), 01111 mul, 10000 div; other codes -> C = 0.
REQ-019 add/sub/neg modulo 2^32; shift/rotate amount = B[4:0].
REQ-020 mul: signed 32x32 -> C = 64-bit signed product.
REQ-021 div: signed; C[31:0] = quotient truncated toward zero, C[63:32] = remainder with sign of A.
REQ-022 div by zero: quotient 32'hFFFFFFFF, remainder = A.
REQ-023 Zin = 1 -> Z_register <= C (64 bits); ZLOin = 1 -> ZLO <= C[31:0]; ZHIin = 1 -> ZHI <= C[63:32]; independent, any combination same cycle.
REQ-024 ALU result captured in the same cycle the operand is on the bus (one-cycle latency to Z/ZLO/ZHI).
REQ-025 Simultaneous load of a register driving the bus: register reloads its own value.

Reset
REQ-026 clr = 0 at rising clk: all registers (R0..R15, HI, LO, PC, IR, MAR, MDR, Y, ZLO, ZHI, Z_register) <= 0; reset overrides all enables.
REQ-027 Reset mid-sequence discards partial results; no state survives.

Configuration
REQ-028 Macro DATAPATH_DIV_EN: defined -> divide (opcode 10000) per REQ-021/022; undefined -> divider not built, opcode 10000 yields C = 0.

Verification
REQ-029 Load R6 = 15, R7 = 4 via Mdatain/MDR; R6out+Yin; R7out, opcode 10000, ZLOin+ZHIin; ZLOout->Loin; ZHIout->HIin -> LO = 3, HI = 3.
REQ-030 Y = -15 (32'hFFFFFFF1), bus = 4, div -> ZLO = 32'hFFFFFFFD, ZHI = 32'hFFFFFFFD; bus = 0 -> ZLO = 32'hFFFFFFFF, ZHI = 32'hFFFFFFF1.
REQ-031 Y = 32'h00010000, bus = 32'h00010000, mul, Zin -> Z_register = 64'h0000000100000000.
REQ-032 R1out and R6out asserted together, R2in -> R2 = R1 value.
REQ-033 PC = 32'hFFFFFFFF, IncPC and PCin with bus = 5 -> PC = 0.
REQ-034 Registers nonzero, clr = 0 one cycle -> all outputs 0 next edge; without DATAPATH_DIV_EN, REQ-029 stimulus -> LO = 0, HI = 0.
